// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM control unit.
// Contents:
//   - state_t: FSM state encoding
//   - ALU_*: ALUControl encodings driven to the datapath
//   - CMD_*: data-processing cmd field values
//   - COND_*: condition field values
//   - OP_*: instruction class field values
//   - helper functions mapping a cmd to its ALU operation and flag class
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Unlisted cmd values fall back to ADD.
    function automatic logic [2:0] cmd_to_alu(input logic [3:0] cmd);
        logic [2:0] r;
        r = ALU_ADD;
        case (cmd)
            CMD_ADD: r = ALU_ADD;
            CMD_SUB: r = ALU_SUB;
            CMD_CMP: r = ALU_SUB;
            CMD_AND: r = ALU_AND;
            CMD_ORR: r = ALU_ORR;
            CMD_EOR: r = ALU_EOR;
            CMD_MOV: r = ALU_MOV;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    // Arithmetic ops are the only ones that produce meaningful C and V.
    function automatic logic cmd_is_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV status register and condition-code evaluation.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset (clears flags)
//   i_cond            : instruction cond field
//   i_alu_flags       : {N,Z,C,V} from the ALU this cycle
//   i_load_nz         : load N and Z from i_alu_flags at the clock edge
//   i_load_cv         : load C and V from i_alu_flags at the clock edge
//   o_flags           : registered {N,Z,C,V}
//   o_cond_pass       : i_cond is satisfied by the registered flags
module arm_cond_unit
    import arm_mc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_load_nz,
    input  logic       i_load_cv,
    output logic [3:0] o_flags,
    output logic       o_cond_pass
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= 4'b0000;
        end else begin
            if (i_load_nz) r_flags[3:2] <= i_alu_flags[3:2];
            if (i_load_cv) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign o_flags = r_flags;

    always_comb begin
        o_cond_pass = 1'b1;
        case (i_cond)
            COND_EQ: o_cond_pass = w_z;
            COND_NE: o_cond_pass = !w_z;
            COND_CS: o_cond_pass = w_c;
            COND_CC: o_cond_pass = !w_c;
            COND_MI: o_cond_pass = w_n;
            COND_PL: o_cond_pass = !w_n;
            COND_VS: o_cond_pass = w_v;
            COND_VC: o_cond_pass = !w_v;
            COND_HI: o_cond_pass = w_c && !w_z;
            COND_LS: o_cond_pass = !w_c || w_z;
            COND_GE: o_cond_pass = (w_n == w_v);
            COND_LT: o_cond_pass = (w_n != w_v);
            COND_GT: o_cond_pass = !w_z && (w_n == w_v);
            COND_LE: o_cond_pass = w_z || (w_n != w_v);
            COND_AL: o_cond_pass = 1'b1;
            COND_NV: o_cond_pass = 1'b1;
            default: o_cond_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: sequences fetch/decode/execute/memory/
// writeback and drives every datapath mux select and write strobe.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   Instr             : instruction register contents
//   ALUFlags          : {N,Z,C,V} from the ALU this cycle
//   adr_lsb           : byte offset of the data address
//   mem_ready         : memory has completed the current request
//   mem_req           : memory access requested this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite : write strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc : mux selects
//   ALUControl        : ALU operation (ADD=0 SUB=1 AND=2 ORR=3 EOR=4 MOV=5)
//   byteEnable        : store lane enables
//   branch_link       : write PC+4 into R14
//   StatusRegister    : registered {N,Z,C,V}
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int ALUCTRL_W     = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic [1:0]           adr_lsb,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           byteEnable,
    output logic                 branch_link,
    output logic [3:0]           StatusRegister
);

    state_t     r_state;
    state_t     w_next;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic       w_imm, w_s_bit, w_load, w_byte, w_link, w_is_cmp;
    logic       w_rdy, w_cond_pass, w_load_nz, w_load_cv;
    logic       w_mem_req, w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_bl;
    logic [3:0] w_be;
    logic [2:0] w_alu_sel;
    logic       w_unused;

    assign w_cond   = Instr[31:28];
    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[25:20];
    assign w_imm    = w_funct[5];
    assign w_cmd    = w_funct[4:1];
    assign w_s_bit  = w_funct[0];
    assign w_load   = w_funct[0];
    assign w_byte   = w_funct[2];
    assign w_link   = w_funct[4];
    assign w_is_cmp = (w_cmd == CMD_CMP);
    assign w_unused = ^Instr[19:0];

    // With the handshake disabled every access completes in one cycle.
    assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    arm_cond_unit u_cond (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_cond      (w_cond),
        .i_alu_flags (ALUFlags),
        .i_load_nz   (w_load_nz),
        .i_load_cv   (w_load_cv),
        .o_flags     (StatusRegister),
        .o_cond_pass (w_cond_pass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_bl        = 1'b0;
        w_be        = 4'b0000;
        w_load_nz   = 1'b0;
        w_load_cv   = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 2'b00;
        w_alu_sel   = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (w_rdy) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC+8 on the ALU so R15 reads see the architectural value.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!w_cond_pass) begin
                    w_next = S_FETCH;
                end else begin
                    case (w_op)
                        OP_DP:   w_next = w_imm ? S_EXECI : S_EXECR;
                        OP_MEM:  w_next = S_MEMADR;
                        OP_BR:   w_next = S_BRANCH;
                        OP_UND:  w_next = S_FETCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b00;
                w_next  = w_load ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                AdrSrc    = 1'b1;
                if (w_rdy) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                // MemWrite stays high for the whole request so the bus
                // sees stable controls across wait states.
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                AdrSrc      = 1'b1;
                w_be        = w_byte ? (4'b0001 << adr_lsb) : 4'b1111;
                if (w_rdy) w_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcB   = 2'b00;
                w_alu_sel = cmd_to_alu(w_cmd);
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB   = 2'b01;
                w_alu_sel = cmd_to_alu(w_cmd);
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                // Keep the ALU on the same operation so ALUFlags are valid
                // for the flag load at this edge.
                ALUSrcB     = w_imm ? 2'b01 : 2'b00;
                w_alu_sel   = cmd_to_alu(w_cmd);
                ResultSrc   = 2'b00;
                w_reg_write = !w_is_cmp;
                w_load_nz   = w_s_bit || w_is_cmp;
                w_load_cv   = (w_s_bit || w_is_cmp) && cmd_is_arith(w_cmd);
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ResultSrc  = 2'b10;
                w_pc_write = 1'b1;
                if (w_link) begin
                    w_bl        = 1'b1;
                    w_reg_write = 1'b1;
                end
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // R15 is read as Rn for branches; Rd is read as the second source for stores.
    assign RegSrc = {(w_op == OP_MEM) && !w_load, (w_op == OP_BR)};

    assign ALUControl = ALUCTRL_W'(w_alu_sel);

    // Strobes are masked by reset directly so an abort takes effect at once.
    assign mem_req     = w_mem_req   && !reset;
    assign PCWrite     = w_pc_write  && !reset;
    assign IRWrite     = w_ir_write  && !reset;
    assign RegWrite    = w_reg_write && !reset;
    assign MemWrite    = w_mem_write && !reset;
    assign branch_link = w_bl        && !reset;
    assign byteEnable  = reset ? 4'b0000 : w_be;

endmodule

// File: tb/tb_arm_mc_controller.sv
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  adr_lsb;
    logic        mem_ready;
    logic        mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, branch_link;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, byteEnable, StatusRegister;

    arm_mc_controller #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .adr_lsb(adr_lsb), .mem_ready(mem_ready), .mem_req(mem_req),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .byteEnable(byteEnable),
        .branch_link(branch_link), .StatusRegister(StatusRegister)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-cycle record of one instruction, index 1 = first fetch cycle.
    logic       rw_c[65], pcw_c[65], mw_c[65], bl_c[65];
    logic [3:0] be_c[65], al_c[65];
    int         n_cyc, stab_err;

    logic [3:0] mflags;   // reference copy of NZCV
    logic [3:0] cmds[7] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010};

    typedef struct {
        int lat, rw_first, rw_n, pcw_n, mw_n, bl_n, exec_cyc;
        logic [3:0] be, flags, aluc;
    } exp_t;

    typedef struct {
        int rw_first, rw_n, pcw_n, mw_n, bl_n, be_stray, triple;
        logic [3:0] be;
    } obs_t;

    // Condition codes come in pairs: odd codes invert the even base test.
    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0], r;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    function automatic logic [3:0] alu_of(logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'd0;
            4'b0010: return 4'd1;
            4'b1010: return 4'd1;
            4'b0000: return 4'd2;
            4'b1100: return 4'd3;
            4'b0001: return 4'd4;
            default: return 4'd5;
        endcase
    endfunction

    // Instruction-level reference: cycle counts, strobe counts, flag effect.
    function automatic exp_t model(logic [31:0] ins, logic [3:0] fl, logic [3:0] af,
                                   logic [1:0] lsb, int fw, int mw);
        exp_t e;
        logic [3:0] cmd = ins[24:21];
        e.lat = 2 + fw; e.rw_first = 0; e.rw_n = 0; e.pcw_n = 1; e.mw_n = 0;
        e.bl_n = 0; e.exec_cyc = 0; e.be = 4'b0000; e.flags = fl; e.aluc = 4'd0;
        if (!cond_ok(ins[31:28], fl)) return e;
        case (ins[27:26])
            2'b00: begin
                e.lat = 4 + fw; e.exec_cyc = 3 + fw; e.aluc = alu_of(cmd);
                if (cmd != 4'b1010) begin e.rw_first = e.lat; e.rw_n = 1; end
                if (ins[20] || cmd == 4'b1010) begin
                    e.flags[3:2] = af[3:2];
                    if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) e.flags[1:0] = af[1:0];
                end
            end
            2'b01: begin
                if (ins[20]) begin
                    e.lat = 5 + fw + mw; e.rw_first = e.lat; e.rw_n = 1;
                end else begin
                    e.lat = 4 + fw + mw; e.mw_n = mw + 1;
                    e.be = ins[22] ? (4'b0001 << lsb) : 4'b1111;
                end
            end
            2'b10: begin
                e.lat = 3 + fw; e.pcw_n = 2;
                if (ins[24]) begin e.rw_first = e.lat; e.rw_n = 1; e.bl_n = 1; end
            end
            default: e.lat = 2 + fw;
        endcase
        return e;
    endfunction

    function automatic obs_t summarize();
        obs_t o;
        o.rw_first = 0; o.rw_n = 0; o.pcw_n = 0; o.mw_n = 0; o.bl_n = 0;
        o.be_stray = 0; o.triple = 0; o.be = 4'b0000;
        for (int k = 1; k <= n_cyc && k < 65; k++) begin
            if (rw_c[k]) begin o.rw_n++; if (o.rw_first == 0) o.rw_first = k; end
            if (pcw_c[k]) o.pcw_n++;
            if (bl_c[k]) o.bl_n++;
            if (pcw_c[k] && rw_c[k] && bl_c[k]) o.triple = k;
            if (mw_c[k]) begin if (o.mw_n == 0) o.be = be_c[k]; o.mw_n++; end
            else if (be_c[k] != 4'b0000) o.be_stray++;
        end
        return o;
    endfunction

    // Drives one instruction from FETCH until the next fetch begins.
    // Entry and exit are just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic [3:0] af, input logic [1:0] lsb);
        int fcnt = 0, mcnt = 0;
        bit fetched = 0, prev_wait = 0, cur_wait;
        logic [31:0] vec, prev_vec = '0;
        n_cyc = 0; stab_err = 0;
        Instr = ins; ALUFlags = af; adr_lsb = lsb;
        for (int k = 0; k < 64; k++) begin
            if (fetched && mem_req && !AdrSrc) return;
            // mem_ready is random when no request is pending; it must be ignored.
            mem_ready = 1'($urandom);
            if (mem_req) begin
                mem_ready = 1'b1;
                if (!AdrSrc) begin
                    if (fcnt < fw) begin mem_ready = 1'b0; fcnt++; end
                end else if (mcnt < mw) begin mem_ready = 1'b0; mcnt++; end
            end
            #1;
            n_cyc++;
            rw_c[n_cyc] = RegWrite; pcw_c[n_cyc] = PCWrite; mw_c[n_cyc] = MemWrite;
            bl_c[n_cyc] = branch_link; be_c[n_cyc] = byteEnable; al_c[n_cyc] = ALUControl;
            vec = {4'b0, mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, byteEnable,
                   branch_link, StatusRegister};
            cur_wait = mem_req && !mem_ready;
            if (prev_wait && cur_wait && vec !== prev_vec) stab_err++;
            prev_wait = cur_wait; prev_vec = vec;
            if (IRWrite) fetched = 1;
            @(posedge clk); #1;
        end
        n_cyc = 99;   // cycle budget exhausted
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; Instr = 32'hE0921003; ALUFlags = 4'b0; adr_lsb = 2'b0;
        repeat (3) @(posedge clk);
        #2;
        n_assert++; if ({mem_req, PCWrite, IRWrite, RegWrite, MemWrite, branch_link} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 000000",
                {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, branch_link}); end
        n_assert++; if (byteEnable !== 4'b0) begin n_fail++; $display("FAIL reset_be: got %b required 0000", byteEnable); end
        n_assert++; if (StatusRegister !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 0000", StatusRegister); end
        @(posedge clk); #1;
        reset = 1'b0; #1;
        n_assert++; if ({mem_req, AdrSrc} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_fetch: got req/adr %b required 10", {mem_req, AdrSrc}); end
        mflags = 4'b0;
    endtask

    task automatic test_adds_z();
        exp_t e = model(32'hE0921003, mflags, 4'b0100, 2'b00, 0, 0);
        obs_t o;
        run_instr(32'hE0921003, 0, 0, 4'b0100, 2'b00);
        o = summarize();
        n_assert++; if (n_cyc !== 4) begin n_fail++; $display("FAIL adds_latency: got %0d required 4", n_cyc); end
        n_assert++; if (o.rw_first !== 4 || o.rw_n !== 1) begin
            n_fail++; $display("FAIL adds_regwrite: got cycle %0d count %0d required cycle 4 count 1", o.rw_first, o.rw_n); end
        n_assert++; if (al_c[3] !== 4'd0) begin n_fail++; $display("FAIL adds_aluctl: got %0d required 0", al_c[3]); end
        n_assert++; if (StatusRegister !== 4'b0100) begin n_fail++; $display("FAIL adds_flags: got %b required 0100", StatusRegister); end
        mflags = e.flags;
    endtask

    task automatic test_ldr_waits();
        obs_t o;
        run_instr(32'hE5912000, 0, 2, 4'b1111, 2'b01);
        o = summarize();
        n_assert++; if (n_cyc !== 7) begin n_fail++; $display("FAIL ldr_latency: got %0d required 7", n_cyc); end
        n_assert++; if (o.rw_first !== 7 || o.rw_n !== 1) begin
            n_fail++; $display("FAIL ldr_regwrite: got cycle %0d count %0d required cycle 7 count 1", o.rw_first, o.rw_n); end
        n_assert++; if (stab_err !== 0) begin n_fail++; $display("FAIL ldr_wait_stable: got %0d changes required 0", stab_err); end
        n_assert++; if (StatusRegister !== mflags) begin n_fail++; $display("FAIL ldr_flags: got %b required %b", StatusRegister, mflags); end
    endtask

    task automatic test_strb();
        obs_t o;
        run_instr(32'hE5C12000, 0, 1, 4'b0000, 2'b10);
        o = summarize();
        n_assert++; if (o.be !== 4'b0100 || o.mw_n !== 2) begin
            n_fail++; $display("FAIL strb_lanes: got be %b writes %0d required be 0100 writes 2", o.be, o.mw_n); end
        n_assert++; if (o.be_stray !== 0) begin n_fail++; $display("FAIL strb_be_idle: got %0d stray cycles required 0", o.be_stray); end
        n_assert++; if (n_cyc !== 5) begin n_fail++; $display("FAIL strb_latency: got %0d required 5", n_cyc); end
        run_instr(32'hE5812000, 0, 0, 4'b0000, 2'b11);
        o = summarize();
        n_assert++; if (o.be !== 4'b1111 || o.mw_n !== 1) begin
            n_fail++; $display("FAIL str_word_lanes: got be %b writes %0d required be 1111 writes 1", o.be, o.mw_n); end
        n_assert++; if (n_cyc !== 4 || o.rw_n !== 0) begin
            n_fail++; $display("FAIL str_latency: got %0d cycles %0d regwrites required 4 and 0", n_cyc, o.rw_n); end
    endtask

    task automatic test_cond_fail();
        obs_t o;
        run_instr(32'hE0921003, 0, 0, 4'b0000, 2'b00);
        mflags = 4'b0000;
        n_assert++; if (StatusRegister !== 4'b0000) begin n_fail++; $display("FAIL cf_setup_flags: got %b required 0000", StatusRegister); end
        run_instr(32'h00821003, 0, 0, 4'b0100, 2'b00);
        o = summarize();
        n_assert++; if (n_cyc !== 2) begin n_fail++; $display("FAIL cf_latency: got %0d required 2", n_cyc); end
        n_assert++; if (o.rw_n !== 0 || o.pcw_n !== 1) begin
            n_fail++; $display("FAIL cf_strobes: got regwrites %0d pcwrites %0d required 0 and 1", o.rw_n, o.pcw_n); end
        n_assert++; if (StatusRegister !== 4'b0000) begin n_fail++; $display("FAIL cf_flags: got %b required 0000", StatusRegister); end
    endtask

    task automatic test_bl();
        obs_t o;
        run_instr(32'hEB000010, 0, 0, 4'b0000, 2'b00);
        o = summarize();
        n_assert++; if (o.triple !== 3) begin
            n_fail++; $display("FAIL bl_strobes: got joint cycle %0d required 3", o.triple); end
        n_assert++; if (n_cyc !== 3 || {mem_req, AdrSrc} !== 2'b10) begin
            n_fail++; $display("FAIL bl_next_fetch: got %0d cycles req/adr %b required 3 and 10", n_cyc, {mem_req, AdrSrc}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ins = $urandom;
            logic [3:0]  af  = 4'($urandom);
            logic [1:0]  lsb = 2'($urandom);
            int fw = $urandom_range(0, 3), mw = $urandom_range(0, 3);
            exp_t e; obs_t o;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'b1110;
            if (ins[27:26] == 2'b00) ins[24:21] = cmds[$urandom_range(0, 6)];
            e = model(ins, mflags, af, lsb, fw, mw);
            run_instr(ins, fw, mw, af, lsb);
            o = summarize();
            n_assert++; if (n_cyc !== e.lat) begin n_fail++; $display("FAIL rnd_latency[%0d] %h: got %0d required %0d", i, ins, n_cyc, e.lat); end
            n_assert++; if (o.rw_first !== e.rw_first || o.rw_n !== e.rw_n) begin
                n_fail++; $display("FAIL rnd_regwrite[%0d] %h: got cycle %0d count %0d required cycle %0d count %0d",
                    i, ins, o.rw_first, o.rw_n, e.rw_first, e.rw_n); end
            n_assert++; if (o.pcw_n !== e.pcw_n) begin n_fail++; $display("FAIL rnd_pcwrite[%0d] %h: got %0d required %0d", i, ins, o.pcw_n, e.pcw_n); end
            n_assert++; if (o.mw_n !== e.mw_n || o.be !== e.be) begin
                n_fail++; $display("FAIL rnd_store[%0d] %h: got writes %0d be %b required writes %0d be %b", i, ins, o.mw_n, o.be, e.mw_n, e.be); end
            n_assert++; if (o.be_stray !== 0) begin n_fail++; $display("FAIL rnd_be_idle[%0d] %h: got %0d required 0", i, ins, o.be_stray); end
            n_assert++; if (o.bl_n !== e.bl_n) begin n_fail++; $display("FAIL rnd_link[%0d] %h: got %0d required %0d", i, ins, o.bl_n, e.bl_n); end
            n_assert++; if (stab_err !== 0) begin n_fail++; $display("FAIL rnd_wait_stable[%0d] %h: got %0d changes required 0", i, ins, stab_err); end
            n_assert++; if (StatusRegister !== e.flags) begin n_fail++; $display("FAIL rnd_flags[%0d] %h: got %b required %b", i, ins, StatusRegister, e.flags); end
            if (e.exec_cyc > 0) begin
                n_assert++; if (al_c[e.exec_cyc] !== e.aluc) begin
                    n_fail++; $display("FAIL rnd_aluctl[%0d] %h: got %0d required %0d", i, ins, al_c[e.exec_cyc], e.aluc); end
            end
            mflags = e.flags;
        end
    endtask

    task automatic test_reset_mid();
        run_instr(32'hE0921003, 0, 0, 4'b1010, 2'b00);
        n_assert++; if (StatusRegister !== 4'b1010) begin n_fail++; $display("FAIL rm_setup_flags: got %b required 1010", StatusRegister); end
        Instr = 32'hE5812000; adr_lsb = 2'b00; mem_ready = 1'b1;
        @(posedge clk); #1;   // DECODE
        @(posedge clk); #1;   // MEMADR
        @(posedge clk); #1;   // MEMWR
        mem_ready = 1'b0; #1;
        n_assert++; if ({mem_req, MemWrite} !== 2'b11) begin n_fail++; $display("FAIL rm_in_memwr: got req/wr %b required 11", {mem_req, MemWrite}); end
        @(posedge clk); #1;
        n_assert++; if (MemWrite !== 1'b1 || byteEnable !== 4'b1111) begin
            n_fail++; $display("FAIL rm_wait_hold: got wr %b be %b required 1 1111", MemWrite, byteEnable); end
        reset = 1'b1; #1;
        n_assert++; if ({mem_req, MemWrite, RegWrite, PCWrite} !== 4'b0 || byteEnable !== 4'b0) begin
            n_fail++; $display("FAIL rm_abort: got strobes %b be %b required 0000 0000",
                {mem_req, MemWrite, RegWrite, PCWrite}, byteEnable); end
        n_assert++; if (StatusRegister !== 4'b0) begin n_fail++; $display("FAIL rm_flags: got %b required 0000", StatusRegister); end
        @(posedge clk); #1;
        reset = 1'b0; #1;
        n_assert++; if ({mem_req, AdrSrc, MemWrite} !== 3'b100) begin
            n_fail++; $display("FAIL rm_refetch: got req/adr/wr %b required 100", {mem_req, AdrSrc, MemWrite}); end
        mflags = 4'b0;
        run_instr(32'hE0921003, 1, 0, 4'b1000, 2'b00);
        n_assert++; if (n_cyc !== 5 || StatusRegister !== 4'b1000) begin
            n_fail++; $display("FAIL rm_after: got %0d cycles flags %b required 5 1000", n_cyc, StatusRegister); end
    endtask

    initial begin
        test_reset();
        test_adds_z();
        test_ldr_waits();
        test_strb();
        test_cond_fail();
        test_bl();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the next-generation ARM core. It replaces the single-cycle controller with a state machine that sequences fetch, decode, execute, memory and writeback over several clocks. It adds a memory ready handshake with unbounded wait states, and condition-code evaluation against a registered NZCV flag set. It sits beside the multicycle datapath in the `arm` top level and drives every datapath mux and write strobe.

## Interface
- `ALUCTRL_W`, default 4: width of the ALUControl encoding.
- `MEM_HANDSHAKE`, default 1: 1 = wait on `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears state and flags.
- `Instr` in 32: instruction register contents (cond[31:28], op[27:26], funct[25:20], Rd[15:12]).
- `ALUFlags` in 4: {N,Z,C,V} from the datapath ALU in the current cycle.
- `adr_lsb` in 2: ALUResult[1:0], the byte offset of the data address.
- `mem_ready` in 1: memory has completed the current request.
- `mem_req` out 1: memory access requested this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1: write strobes.
- `AdrSrc` out 1: 0 = PC, 1 = ALU-result register.
- `ALUSrcA` out 1; `ALUSrcB` out 2; `ResultSrc` out 2; `ImmSrc` out 2; `RegSrc` out 2: datapath mux selects.
- `ALUControl` out `ALUCTRL_W`: ADD=0, SUB=1, AND=2, ORR=3, EOR=4, MOV=5.
- `byteEnable` out 4: store lane enables.
- `branch_link` out 1: writes PC+4 into R14.
- `StatusRegister` out 4: registered {N,Z,C,V}.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- **FETCH**
  - `mem_req`=1, `AdrSrc`=0.
  - ALU computes PC+4 (`ALUSrcA`=1, `ALUSrcB`=2'b10, ADD, `ResultSrc`=2'b10).
  - `IRWrite` and `PCWrite` pulse only in the cycle `mem_ready`=1; the state then goes to DECODE. Otherwise it stays in FETCH.
- **DECODE**
  - Computes PC+8 for R15 reads.
  - Evaluates cond against `StatusRegister` using the standard 15 ARM codes; AL=1110 and 1111 pass.
  - Cond fail → FETCH (instruction retired as a NOP).
  - Otherwise the next state is set by op:
    - op=00, I=0 → EXECR; op=00, I=1 → EXECI.
    - op=01 → MEMADR.
    - op=10 → BRANCH.
    - op=11 → FETCH (undefined, treated as a NOP).
- **MEMADR**
  - Base + imm12 (`ImmSrc`=00, ADD).
  - L=1 → MEMRD; L=0 → MEMWR.
- **MEMRD**
  - `mem_req`=1, `AdrSrc`=1.
  - Holds until `mem_ready`, then → MEMWB.
- **MEMWB**
  - `ResultSrc`=01, `RegWrite`=1, then → FETCH.
  - LDRB: the datapath zero-extends the lane selected by `adr_lsb`.
- **MEMWR**
  - `mem_req`=1, `MemWrite`=1, `AdrSrc`=1.
  - Holds until `mem_ready`, then → FETCH.
  - `byteEnable` = 4'b1111 for a word store. For STRB (B=funct[2]) it is the one-hot of `adr_lsb`.
  - `byteEnable` is 0 in every other state.
- **EXECR / EXECI**
  - ALU op from cmd=funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (uses SUB).
  - Then → ALUWB.
- **ALUWB**
  - `RegWrite`=1 except for CMP.
  - Flags load from `ALUFlags` when S=funct[0]=1 or the op is CMP.
  - N and Z always load. C and V load only for ADD, SUB and CMP.
  - Then → FETCH.
- **BRANCH**
  - PC ← PC+8 + (imm24<<2) (`ImmSrc`=10, `PCWrite`=1).
  - When funct[4]=1 (BL): `branch_link`=1 and `RegWrite`=1, R14 ← PC+4.
  - Then → FETCH.
- Strobes not listed for a state are 0.

## Timing
- Reset:
  - State = FETCH, `StatusRegister`=0.
  - While `reset` is high every write strobe, `mem_req` and `byteEnable` are forced to 0.
  - First fetch request is in the first cycle after deassertion.
- Reset asserted mid-access: the state machine aborts immediately and no partial writes are issued.
- Latency with zero wait states:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Cond-fail: 2 cycles.
- Each cycle with `mem_ready`=0 adds one cycle in FETCH, MEMRD or MEMWR.
- While waiting, all outputs hold stable.
- `mem_ready` is sampled only while `mem_req`=1.
- `StatusRegister` changes only at the ALUWB clock edge. It is visible to the next instruction's DECODE.

## Structure
- Package `arm_mc_pkg` holds:
  - the state enum;
  - ALUControl localparams;
  - cmd and cond code constants;
  - the op field constants.
- Sub-module `arm_cond_unit` holds:
  - the NZCV flag register with its load enables;
  - the combinational cond-pass evaluation.
- The FSM and output decode stay in `arm_mc_controller`.

## Test plan
- **ADDS with Z result:** ADDS R1,R2,R3 with ALUFlags=0100 and no waits → `RegWrite` in cycle 4; `StatusRegister`=0100 after the edge.
- **LDR with waits:** LDR with `mem_ready` low for 2 MEMRD cycles → MEMWB `RegWrite` in cycle 7; no `RegWrite` earlier.
- **STRB lane select:** STRB with `adr_lsb`=2'b10 → `byteEnable`=4'b0100 with `MemWrite`=1 in MEMWR. Word STR → 4'b1111.
- **Cond fail:** ADDEQ with Z=0 → FETCH after DECODE; no `RegWrite`/`PCWrite` beyond the fetch pulse; flags unchanged.
- **BL:** BL → `PCWrite`, `RegWrite` and `branch_link` all 1 in the BRANCH cycle; next state FETCH.
- **Reset mid-access:** `reset` pulsed during MEMWR wait → `MemWrite`=0 at once; state FETCH; `StatusRegister`=0; `mem_req` reasserts in the first cycle after release.
